// File: rtl/vliw_pkg.sv
// Shared opcode values, sequencer states and slot field positions for the two-slot bundle sequencer.
package vliw_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ALU_A = 3'b001;
    localparam logic [2:0] OP_ALU_B = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int OPC_HI    = 15;
    localparam int OPC_LO    = 13;
    localparam int AMODE_BIT = 12;
    localparam int DEST_HI   = 11;
    localparam int DEST_LO   = 8;
    localparam int SRC_HI    = 7;
    localparam int SRC_LO    = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_MEM_A,
        S_MEM_B,
        S_HALT
    } seqState_t;

endpackage

// File: rtl/vliw_slot_decode.sv
// Purely combinational decode of one 16-bit slot into class flags and its Destination/Source fields.
// Zero latency; no handshake.
module vliw_slot_decode
    import vliw_pkg::*;
(
    input  logic [15:0] slot,
    output logic        is_alu,
    output logic        is_load,
    output logic        is_store,
    output logic        is_halt,
    output logic [3:0]  dest,
    output logic [7:0]  src
);

    logic [2:0] opc;
    logic       unusedMode;

    assign opc        = slot[OPC_HI:OPC_LO];
    assign unusedMode = slot[AMODE_BIT];

    // Reserved opcodes 101/110 fall through as NOP.
    assign is_alu   = (opc == OP_ALU_A) || (opc == OP_ALU_B);
    assign is_load  = (opc == OP_LOAD);
    assign is_store = (opc == OP_STORE);
    assign is_halt  = (opc == OP_HALT);
    assign dest     = slot[DEST_HI:DEST_LO];
    assign src      = slot[SRC_HI:SRC_LO];

endmodule

// File: rtl/bundle_sequencer.sv
// Two-slot bundle sequencer: fetch, issue ALU writes, then serialise memory ops slot0-first.
// Each bundle costs FETCH+ISSUE plus one MEM state per memory slot; MEM states stall until MemReady.
module bundle_sequencer
    import vliw_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    output logic [PC_W-1:0] InstrAddr,
    input  logic [31:0]     InstrData,
    output logic [1:0]      RegWrite,
    output logic [3:0]      RegDest0,
    output logic [3:0]      RegDest1,
    output logic            MemReq,
    output logic            MemWrite,
    output logic [7:0]      MemAddr,
    output logic            MemSlot,
    input  logic            MemReady,
    output logic            Busy,
    output logic            Halted
);

    seqState_t       state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcNext;
    logic [31:0]     bundleQ;
    logic [31:0]     curBundle;
    logic [1:0]      aluWr;
    logic [1:0]      rawWr;
    logic            loadDone;

    logic       alu0, ld0, st0, hl0;
    logic       alu1, ld1, st1, hl1;
    logic [3:0] dst0, dst1;
    logic [7:0] src0, src1;
    logic       mem0, mem1, anyHalt;

    // The fresh bundle is only on InstrData during ISSUE; later states use the latched copy.
    assign curBundle = (state == S_ISSUE) ? InstrData : bundleQ;

    vliw_slot_decode uDec0 (
        .slot     (curBundle[31:16]),
        .is_alu   (alu0),
        .is_load  (ld0),
        .is_store (st0),
        .is_halt  (hl0),
        .dest     (dst0),
        .src      (src0)
    );

    vliw_slot_decode uDec1 (
        .slot     (curBundle[15:0]),
        .is_alu   (alu1),
        .is_load  (ld1),
        .is_store (st1),
        .is_halt  (hl1),
        .dest     (dst1),
        .src      (src1)
    );

    assign mem0    = ld0 | st0;
    assign mem1    = ld1 | st1;
    assign anyHalt = hl0 | hl1;
    assign pcNext  = pc + 1'b1;

    // Load write-back lands in the same cycle memory signals completion.
    assign loadDone = MemReq & MemReady & ~MemWrite;
    assign rawWr    = aluWr | {loadDone & MemSlot, loadDone & ~MemSlot};
    assign RegWrite = ((rawWr == 2'b11) && (RegDest0 == RegDest1)) ? 2'b10 : rawWr;

    assign Busy   = (state == S_FETCH) || (state == S_ISSUE) ||
                    (state == S_MEM_A) || (state == S_MEM_B);
    assign Halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            InstrAddr <= '0;
            bundleQ   <= '0;
            aluWr     <= 2'b00;
            RegDest0  <= 4'd0;
            RegDest1  <= 4'd0;
            MemReq    <= 1'b0;
            MemWrite  <= 1'b0;
            MemAddr   <= 8'd0;
            MemSlot   <= 1'b0;
        end else begin
            aluWr <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        pc        <= '0;
                        InstrAddr <= '0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_ISSUE;
                S_ISSUE: begin
                    bundleQ  <= InstrData;
                    RegDest0 <= dst0;
                    RegDest1 <= dst1;
                    aluWr    <= {alu1, alu0};
                    if (mem0 || mem1) begin
                        state    <= S_MEM_A;
                        MemReq   <= 1'b1;
                        MemSlot  <= ~mem0;
                        MemAddr  <= mem0 ? src0 : src1;
                        MemWrite <= mem0 ? st0 : st1;
                    end else if (anyHalt) begin
                        state <= S_HALT;
                    end else begin
                        pc        <= pcNext;
                        InstrAddr <= pcNext;
                        state     <= S_FETCH;
                    end
                end
                S_MEM_A, S_MEM_B: begin
                    if (MemReady) begin
                        if (state == S_MEM_A && mem0 && mem1) begin
                            state    <= S_MEM_B;
                            MemSlot  <= 1'b1;
                            MemAddr  <= src1;
                            MemWrite <= st1;
                        end else begin
                            MemReq   <= 1'b0;
                            MemWrite <= 1'b0;
                            if (anyHalt) begin
                                state <= S_HALT;
                            end else begin
                                pc        <= pcNext;
                                InstrAddr <= pcNext;
                                state     <= S_FETCH;
                            end
                        end
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Table-driven bench for bundle_sequencer with an event scoreboard and a stalling memory responder.
module tb_bundle_sequencer;

    typedef struct packed {
        logic       isMem;
        logic [1:0] rw;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       slot;
        logic [7:0] addr;
        logic       wr;
    } evt_t;

    typedef struct packed {
        logic [31:0]    bundle;
        logic [1:0]     nEv;
        evt_t [2:0]     ev;
        logic [7:0]     memCnt;
        logic [7:0]     finalAddr;
    } vec_t;

    localparam int NVEC = 6;
    localparam evt_t NOEV = '0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  InstrAddr;
    logic [31:0] InstrData;
    logic [1:0]  RegWrite;
    logic [3:0]  RegDest0, RegDest1;
    logic        MemReq, MemWrite, MemSlot, Busy, Halted;
    logic [7:0]  MemAddr;
    logic        MemReady = 1'b0;

    logic [31:0] imem [256];
    evt_t        sbq[$];
    vec_t        vecs [NVEC];
    int          checks = 0;
    int          failures = 0;
    int          memWait = 2;
    int          memCnt = 0;

    bundle_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start),
        .InstrAddr(InstrAddr), .InstrData(InstrData),
        .RegWrite(RegWrite), .RegDest0(RegDest0), .RegDest1(RegDest1),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
        .MemSlot(MemSlot), .MemReady(MemReady),
        .Busy(Busy), .Halted(Halted)
    );

    always #5 clk = ~clk;
    assign InstrData = imem[InstrAddr];

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [3:0] d, input logic [7:0] s);
        return {op, 1'b0, d, s};
    endfunction

    function automatic evt_t rwEv(input logic [1:0] rw, input logic [3:0] d0, input logic [3:0] d1);
        evt_t e = '0;
        e.rw = rw; e.d0 = d0; e.d1 = d1;
        return e;
    endfunction

    function automatic evt_t memEv(input logic slot, input logic [7:0] addr, input logic wr);
        evt_t e = '0;
        e.isMem = 1'b1; e.slot = slot; e.addr = addr; e.wr = wr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder drives MemReady just after the edge; monitor samples at the falling edge.
    initial begin
        int   rdyCnt = 0;
        logic prevReq = 1'b0, prevReady = 1'b0, prevWr = 1'b0, prevSlot = 1'b0;
        logic [7:0] prevAddr = 8'd0;
        evt_t e;
        forever begin
            @(posedge clk);
            #1;
            if (MemReq) begin
                if (rdyCnt >= memWait) begin MemReady = 1'b1; rdyCnt = 0; end
                else begin MemReady = 1'b0; rdyCnt++; end
            end else begin
                MemReady = 1'b0; rdyCnt = 0;
            end
            @(negedge clk);
            if (!rst_n) begin
                prevReq = 1'b0; prevReady = 1'b0;
            end else begin
                if (MemReq) begin
                    memCnt++;
                    if (!prevReq || prevReady) begin
                        if (sbq.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_mem_grant slot=%0d addr=%0h", MemSlot, MemAddr);
                        end else begin
                            e = sbq.pop_front();
                            chk("grant_kind", {31'd0, 1'b1}, {31'd0, e.isMem});
                            chk("grant_slot", {31'd0, MemSlot}, {31'd0, e.slot});
                            chk("grant_addr", {24'd0, MemAddr}, {24'd0, e.addr});
                            chk("grant_write", {31'd0, MemWrite}, {31'd0, e.wr});
                        end
                    end else begin
                        chk("hold_stable", {22'd0, MemSlot, MemWrite, MemAddr},
                            {22'd0, prevSlot, prevWr, prevAddr});
                    end
                end
                if (RegWrite != 2'b00) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_regwrite got=%0b", RegWrite);
                    end else begin
                        e = sbq.pop_front();
                        chk("rw_kind", {31'd0, 1'b0}, {31'd0, e.isMem});
                        chk("rw_strobe", {30'd0, RegWrite}, {30'd0, e.rw});
                        chk("rw_dest", {24'd0, RegDest0, RegDest1}, {24'd0, e.d0, e.d1});
                    end
                end
                prevReq = MemReq; prevReady = MemReady;
                prevAddr = MemAddr; prevWr = MemWrite; prevSlot = MemSlot;
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; Start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
    endtask

    task automatic pulseStart();
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
    endtask

    task automatic waitHalt(input string name);
        for (int c = 0; c < 300 && !Halted; c++) @(negedge clk);
        chk(name, {31'd0, Halted}, 32'd1);
    endtask

    task automatic clearImem();
        for (int a = 0; a < 256; a++) imem[a] = 32'd0;
    endtask

    initial begin
        logic [31:0] haltB;
        haltB = {mk(3'b111, 4'd0, 8'd0), 16'h0000};

        vecs[0] = '{bundle: {mk(3'b001, 4'd3, 8'd0), mk(3'b010, 4'd5, 8'd0)}, nEv: 2'd1,
                    ev: {NOEV, NOEV, rwEv(2'b11, 4'd3, 4'd5)}, memCnt: 8'd0, finalAddr: 8'd1};
        vecs[1] = '{bundle: {mk(3'b100, 4'd0, 8'h20), mk(3'b011, 4'd7, 8'h40)}, nEv: 2'd3,
                    ev: {rwEv(2'b10, 4'd0, 4'd7), memEv(1'b1, 8'h40, 1'b0), memEv(1'b0, 8'h20, 1'b1)},
                    memCnt: 8'd6, finalAddr: 8'd1};
        vecs[2] = '{bundle: {mk(3'b001, 4'd4, 8'd0), mk(3'b010, 4'd4, 8'd0)}, nEv: 2'd1,
                    ev: {NOEV, NOEV, rwEv(2'b10, 4'd4, 4'd4)}, memCnt: 8'd0, finalAddr: 8'd1};
        vecs[3] = '{bundle: {mk(3'b011, 4'd2, 8'h33), mk(3'b001, 4'd9, 8'd0)}, nEv: 2'd3,
                    ev: {rwEv(2'b01, 4'd2, 4'd9), rwEv(2'b10, 4'd2, 4'd9), memEv(1'b0, 8'h33, 1'b0)},
                    memCnt: 8'd3, finalAddr: 8'd1};
        vecs[4] = '{bundle: {mk(3'b101, 4'd1, 8'd1), mk(3'b110, 4'd2, 8'd2)}, nEv: 2'd0,
                    ev: {NOEV, NOEV, NOEV}, memCnt: 8'd0, finalAddr: 8'd1};
        vecs[5] = '{bundle: {mk(3'b111, 4'd0, 8'd0), mk(3'b100, 4'd0, 8'h10)}, nEv: 2'd1,
                    ev: {NOEV, NOEV, memEv(1'b1, 8'h10, 1'b1)}, memCnt: 8'd3, finalAddr: 8'd0};

        clearImem();
        #1;
        chk("reset_outputs", {13'd0, InstrAddr, RegWrite, RegDest0, RegDest1, MemReq, MemWrite, MemSlot},
            32'd0);
        chk("reset_memaddr", {24'd0, MemAddr}, 32'd0);
        chk("reset_status", {30'd0, Busy, Halted}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            doReset();
            clearImem();
            imem[0] = vecs[i].bundle;
            imem[1] = haltB;
            memWait = 2;
            memCnt = 0;
            for (int k = 0; k < int'(vecs[i].nEv); k++) sbq.push_back(vecs[i].ev[k]);
            pulseStart();
            waitHalt($sformatf("v%0d_halts", i));
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_events_left", i), sbq.size(), 32'd0);
            chk($sformatf("v%0d_mem_cycles", i), memCnt, {24'd0, vecs[i].memCnt});
            chk($sformatf("v%0d_final_addr", i), {24'd0, InstrAddr}, {24'd0, vecs[i].finalAddr});
            chk($sformatf("v%0d_busy_low", i), {31'd0, Busy}, 32'd0);
        end

        // Halted machine must ignore a fresh Start.
        pulseStart();
        repeat (10) @(negedge clk);
        chk("halt_ignores_start", {22'd0, Halted, Busy, InstrAddr, MemReq, RegWrite != 2'b00},
            {22'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0});

        // PC wrap across an all-NOP program.
        doReset();
        clearImem();
        pulseStart();
        for (int c = 0; c < 1000 && InstrAddr != 8'd255; c++) @(negedge clk);
        chk("wrap_reach_255", {24'd0, InstrAddr}, 32'd255);
        for (int c = 0; c < 10 && InstrAddr == 8'd255; c++) @(negedge clk);
        chk("wrap_to_zero", {24'd0, InstrAddr}, 32'd0);
        chk("wrap_busy", {31'd0, Busy}, 32'd1);

        // Reset while a store is waiting on memory.
        doReset();
        clearImem();
        imem[0] = {mk(3'b100, 4'd0, 8'h55), 16'h0000};
        memWait = 1000;
        sbq.push_back(memEv(1'b0, 8'h55, 1'b1));
        pulseStart();
        for (int c = 0; c < 20 && !MemReq; c++) @(negedge clk);
        chk("midop_memreq_up", {31'd0, MemReq}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midop_memreq_drop", {31'd0, MemReq}, 32'd0);
        chk("midop_no_write", {30'd0, RegWrite}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        memWait = 2;
        @(negedge clk);
        chk("midop_idle", {22'd0, Busy, Halted, InstrAddr}, 32'd0);
        chk("midop_events_left", sbq.size(), 32'd0);
        imem[0] = haltB;
        pulseStart();
        waitHalt("midop_restart_halts");
        chk("midop_restart_pc0", {24'd0, InstrAddr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
